// File: rtl/port_alloc_ctrl.sv
// Packet-aware round-robin allocator for one router output port; holds the grant from header to tail.
// Latency: grant/sel/busy one cycle after an eligible header; one idle cycle between packets.
// Backpressure: out_ready low or owner req low holds the grant with fwd=0; only the watchdog releases it.
module port_alloc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req,
  input  logic [14:0] flit_id,
  input  logic [59:0] length,
  input  logic        out_ready,
  output logic [4:0]  grant,
  output logic [2:0]  sel,
  output logic        fwd,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  owner_q, owner_d;
  logic [11:0] len_q, len_d;
  logic [11:0] count_q, count_d;
  logic        timeout_q, timeout_d;

  logic [4:0]  eligible;
  logic        any_elig;
  logic [2:0]  win;
  logic [11:0] win_len;
  logic        owner_req;
  logic        owner_tail;
  logic        tail_rel;
  logic        wd_rel;
  logic [2:0]  owner_next_ptr;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      eligible[i] = req[i] & flit_id[3*i];
    end
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win      = 3'd0;
    any_elig = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= 5) j = j - 5;
      if (eligible[j]) begin
        win      = 3'(j);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    win_len    = 12'd0;
    owner_req  = 1'b0;
    owner_tail = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (win == 3'(i)) win_len = length[12*i +: 12];
      if (owner_q == 3'(i)) begin
        owner_req  = req[i];
        owner_tail = flit_id[3*i+2];
      end
    end
  end

  assign fwd            = (state_q == LOCKED) & owner_req & out_ready;
  assign tail_rel       = fwd & owner_tail;
  assign wd_rel         = (len_q != 12'd0) && (count_q == len_q - 12'd1) && !tail_rel;
  assign owner_next_ptr = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 3'd0;
      owner_q   <= 3'd0;
      len_q     <= 12'd0;
      count_q   <= 12'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      len_q     <= len_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    len_d     = len_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = LOCKED;
          owner_d = win;
          len_d   = win_len;
          count_d = 12'd0;
        end
      end
      LOCKED: begin
        count_d = (count_q == 12'hFFF) ? count_q : count_q + 12'd1;
        if (tail_rel || wd_rel) begin
          state_d   = IDLE;
          rr_ptr_d  = owner_next_ptr;
          timeout_d = wd_rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = 5'd0;
    for (int i = 0; i < 5; i++) begin
      if (state_q == LOCKED && owner_q == 3'(i)) grant[i] = 1'b1;
    end
    sel     = (state_q == LOCKED) ? owner_q : 3'd7;
    busy    = (state_q == LOCKED);
    timeout = timeout_q;
  end

endmodule

// File: tb/tb_port_alloc_ctrl.sv
// Directed and random stimulus for port_alloc_ctrl, checked each cycle against a packet-level model.
module tb_port_alloc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] flit_id;
  logic [59:0] length;
  logic        out_ready;
  logic [4:0]  grant;
  logic [2:0]  sel;
  logic        fwd;
  logic        timeout;
  logic        busy;

  port_alloc_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .out_ready(out_ready), .grant(grant), .sel(sel), .fwd(fwd),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Packet-level reference: who owns the port, its length, cycles held so far, next scan start.
  bit m_busy;
  int m_owner;
  int m_len;
  int m_elapsed;
  int m_rr;
  bit m_timeout;

  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] B  = 3'b010;
  localparam logic [2:0] T  = 3'b100;
  localparam logic [2:0] SF = 3'b101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] fp(input int p, input logic [2:0] c);
    return 15'(c) << (3*p);
  endfunction

  function automatic logic [59:0] lp(input int p, input int v);
    return 60'(v & 32'hFFF) << (12*p);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_len = 0; m_elapsed = 0; m_rr = 0; m_timeout = 0;
  endtask

  task automatic model_next();
    bit found, xfer, tail, wd;
    int p;
    if (!m_busy) begin
      m_timeout = 0;
      found = 0;
      for (int k = 0; k < 5; k++) begin
        p = (m_rr + k) % 5;
        if (!found && req[p] && flit_id[3*p]) begin
          found = 1; m_busy = 1; m_owner = p; m_elapsed = 0;
          m_len = int'(length[12*p +: 12]);
        end
      end
    end else begin
      xfer = req[m_owner] && out_ready;
      tail = xfer && flit_id[3*m_owner+2];
      wd   = (m_len != 0) && (m_elapsed + 1 == m_len) && !tail;
      if (tail || wd) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % 5;
        m_timeout = wd;
      end else begin
        m_elapsed++;
        m_timeout = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0] eg;
    logic [2:0] es;
    logic       ef;
    eg = m_busy ? 5'(1 << m_owner) : 5'd0;
    es = m_busy ? 3'(m_owner) : 3'd7;
    ef = m_busy && req[m_owner] && out_ready;
    chk("grant",   32'(grant),   32'(eg));
    chk("sel",     32'(sel),     32'(es));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("fwd",     32'(fwd),     32'(ef));
  endtask

  task automatic step(input logic [4:0] r, input logic [14:0] f, input logic [59:0] l, input logic rdy);
    req = r; flit_id = f; length = l; out_ready = rdy;
    @(negedge clk);
    check_outputs();
    model_next();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] codes [6];
    logic [14:0] rf;
    logic [59:0] rl;
    codes[0] = H; codes[1] = B; codes[2] = T; codes[3] = SF; codes[4] = 3'b000; codes[5] = 3'b011;

    rst = 1'b0; req = '0; flit_id = '0; length = '0; out_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd7);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // Priority after reset, then a four-flit packet from L
    step(5'b00101, fp(0, H) | fp(2, H), '0, 1'b1);
    chk("first_grant", 32'(grant), 32'h01);
    chk("first_sel", 32'(sel), 32'd0);
    step(5'b00001, fp(0, H), '0, 1'b1);
    step(5'b00001, fp(0, B), '0, 1'b1);
    step(5'b00001, fp(0, B), '0, 1'b1);
    step(5'b00001, fp(0, T), '0, 1'b1);
    chk("rel_after_tail", 32'(grant), 32'd0);

    // Rotation: E beats L, then scan resumes from W
    step(5'b00101, fp(0, H) | fp(2, H), '0, 1'b1);
    chk("rr_grant_E", 32'(grant), 32'h04);
    step(5'b00100, fp(2, H), '0, 1'b1);
    step(5'b00100, fp(2, T), '0, 1'b1);
    step(5'b10011, fp(0, H) | fp(1, H) | fp(4, H), '0, 1'b1);
    chk("rr_grant_S", 32'(grant), 32'h10);

    // Backpressure mid-packet
    step(5'b10000, fp(4, H), '0, 1'b1);
    for (int i = 0; i < 3; i++) step(5'b10000, fp(4, B), '0, 1'b0);
    chk("bp_hold", 32'(grant), 32'h10);
    step(5'b10000, fp(4, B), '0, 1'b1);
    step(5'b10000, fp(4, T), '0, 1'b1);

    // Watchdog expiry on W with length 4
    step(5'b01000, fp(3, H), lp(3, 4), 1'b1);
    for (int i = 0; i < 4; i++) step(5'b01000, fp(3, B), lp(3, 9), 1'b1);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_grant0", 32'(grant), 32'd0);
    step(5'b00011, fp(0, H) | fp(1, H), '0, 1'b1);
    chk("wd_next_L", 32'(grant), 32'h01);
    step(5'b00001, fp(0, T), '0, 1'b1);

    // Tail in the fourth locked cycle beats the watchdog
    step(5'b01000, fp(3, H), lp(3, 4), 1'b1);
    for (int i = 0; i < 3; i++) step(5'b01000, fp(3, B), '0, 1'b1);
    step(5'b01000, fp(3, T), '0, 1'b1);
    chk("tail_beats_wd", 32'(timeout), 32'd0);
    step(5'b00000, '0, '0, 1'b1);

    // Length 0 disables the watchdog across a long stall
    step(5'b00010, fp(1, H), lp(1, 0), 1'b1);
    for (int i = 0; i < 5000; i++) step(5'b00010, fp(1, B), '0, 1'b0);
    chk("len0_still_busy", 32'(busy), 32'd1);
    step(5'b00010, fp(1, T), '0, 1'b1);

    // Single-flit packet on S, pointer wraps to L
    step(5'b10000, fp(4, SF), '0, 1'b1);
    step(5'b10000, fp(4, SF), '0, 1'b1);
    step(5'b00011, fp(0, H) | fp(1, H), '0, 1'b1);
    chk("wrap_L", 32'(grant), 32'h01);

    // Asynchronous reset while L owns the port
    step(5'b00001, fp(0, B), '0, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_sel", 32'(sel), 32'd7);
    chk("arst_busy", 32'(busy), 32'd0);
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    step(5'b00110, fp(1, H) | fp(2, H), '0, 1'b1);
    chk("arst_next_N", 32'(grant), 32'h02);
    step(5'b00010, fp(1, T), '0, 1'b1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rf = '0;
      rl = '0;
      for (int p = 0; p < 5; p++) begin
        rf = rf | fp(p, codes[$urandom_range(0, 5)]);
        rl = rl | lp(p, int'($urandom_range(0, 9)));
      end
      step(5'($urandom_range(0, 31)), rf, rl, 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
